imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 n_reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately, independent of clk.
REQ-003 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  stage accepts an instruction this cycle.
REQ-006 in_instr  input  32  raw RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 out_valid  output  1  decoded entry available to execute.
REQ-009 out_ready  input  1  execute consumes the entry.
REQ-010 out_pc  output  32  PC of the decoded entry.
REQ-011 out_imm  output  32  fully sign-extended immediate.
REQ-012 out_fmt  output  3  immediate format: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-013 out_rd, out_rs1, out_rs2  output  5 each  register fields, passed through unmodified.
REQ-014 out_opcode  output  7  instr[6:0].
REQ-015 out_funct3  output  3  instr[14:12].
REQ-016 out_illegal  output  1  opcode not in RV32I base set.

Function
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-018 Storage: one output register (OUT) plus one skid register (SKID); states EMPTY (neither valid), ONE (OUT valid), FULL (both valid).
REQ-019 in_ready shall be a registered signal equal to !SKID.valid; it shall carry no combinational path from out_ready.
REQ-020 EMPTY: transfer in -> ONE.
REQ-021 ONE: transfer in only -> FULL if no transfer out; transfer in and transfer out -> ONE, new entry in OUT; transfer out only -> EMPTY.
REQ-022 FULL: transfer out -> SKID moves into OUT, state ONE; no transfer in is possible.
REQ-023 Decode is performed before storage; latency is one cycle, from input transfer to out_valid.
REQ-024 Order is preserved; with out_ready held high, throughput is one instruction per cycle.
REQ-025 I-format (opcodes 0010011, 0000011, 1100111, 1110011): imm = sext(instr[31:20]).
REQ-026 S-format (0100011): imm = sext({instr[31:25], instr[11:7]}).
REQ-027 B-format (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-028 U-format (0110111, 0010111): imm = {instr[31:12], 12'b0}.
REQ-029 J-format (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-030 R-format (0110011) and the FENCE opcode (0001111): imm = 0, fmt = R, with FENCE reported as fmt I and imm = sext(instr[31:20]).
REQ-031 Sign fill is always instr[31]: 20 bits for I/S, 19 bits for B, 11 bits for J.
REQ-032 Any other opcode: out_illegal = 1, imm = 0, fmt = R; the entry still flows through the handshake normally.
REQ-033 flush: both valids cleared at the next edge and in_ready = 1; a same-cycle in_valid is dropped; flush overrides all other events.
REQ-034 Data fields of invalid entries are don't-care; verification shall not check them.

Reset
REQ-035 On n_reset low: out_valid = 0, SKID.valid = 0, in_ready = 0; all data registers = 0.
REQ-036 in_ready shall rise on the first clk edge after n_reset deasserts.
REQ-037 Reset during a transfer discards the entry; no partial entry shall appear after reset.

Structure
REQ-038 A shared package shall hold the opcode constants, the fmt enum, and a packed decoded-entry struct (pc, imm, fmt, rd, rs1, rs2, opcode, funct3, illegal).
REQ-039 Immediate assembly and sign fill shall live in one combinational sub-module, imm_assemble (instr in; imm, fmt, illegal out); the stage instantiates it once, on the input side.

Verification
REQ-040 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=I, rd=1.
REQ-041 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt=S, rs1=2, rs2=1.
REQ-042 0xFF9FF06F (jal x0,-8) -> out_imm=0xFFFFFFF8, fmt=J; 0x123450B7 (lui) -> out_imm=0x12345000, fmt=U.
REQ-043 Stream of 3 instructions with out_ready=0 -> stage holds 2, in_ready=0 on the 3rd; release out_ready -> all 3 emerge in order, no loss.
REQ-044 Stage FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry never appears; opcode 0x7F -> out_illegal=1, imm=0.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats,
// skid-stage states and the packed decoded-entry record.
package imm_decode_stage_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        illegal;
    } dec_entry_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-execute handshake bundle around the decode stage; the stage
// takes the slave side, fetch/execute (or a bench) takes the master side.
interface imm_decode_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_fmt,
               out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_fmt,
               out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_illegal
    );

endinterface

// File: rtl/imm_decode_stage_imm.sv
// Combinational RV32I immediate assembly, sign fill and legality check.
// Zero latency, no state, no backpressure.
module imm_assemble
    import imm_decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o,
    output fmt_e        fmt_o,
    output logic        illegal_o
);

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        unique case (instr_i[6:0])
            // FENCE carries a 12-bit field in the I slot, so it decodes as I.
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
                fmt_o = FMT_I;
                imm_o = sext12(instr_i[31:20]);
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm_o = sext12({instr_i[31:25], instr_i[11:7]});
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt_o = FMT_R;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage with OUT + SKID registers; one cycle from accept to out_valid,
// full rate under out_ready. in_ready is registered (!SKID valid), no comb path from out_ready.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
(
    input  logic               clk,
    input  logic               n_reset,
    input  logic               flush,
    imm_decode_stage_if.slave  bus
);

    logic [31:0] dec_imm;
    fmt_e        dec_fmt;
    logic        dec_illegal;
    dec_entry_t  dec_d;

    state_e      state_q;
    dec_entry_t  out_q;
    dec_entry_t  skid_q;
    logic        out_vld_q;
    logic        in_rdy_q;

    logic        xfer_in;
    logic        xfer_out;

    imm_assemble u_imm_assemble (
        .instr_i   (bus.in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        dec_d         = '0;
        dec_d.pc      = bus.in_pc;
        dec_d.imm     = dec_imm;
        dec_d.fmt     = dec_fmt;
        dec_d.rd      = bus.in_instr[11:7];
        dec_d.rs1     = bus.in_instr[19:15];
        dec_d.rs2     = bus.in_instr[24:20];
        dec_d.opcode  = bus.in_instr[6:0];
        dec_d.funct3  = bus.in_instr[14:12];
        dec_d.illegal = dec_illegal;
    end

    assign xfer_in  = bus.in_valid & in_rdy_q;
    assign xfer_out = out_vld_q & bus.out_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_EMPTY;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state_q   <= ST_EMPTY;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    in_rdy_q <= 1'b1;
                    if (xfer_in) begin
                        out_q     <= dec_d;
                        out_vld_q <= 1'b1;
                        state_q   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        out_q <= dec_d;
                    end else if (xfer_in) begin
                        skid_q   <= dec_d;
                        in_rdy_q <= 1'b0;
                        state_q  <= ST_FULL;
                    end else if (xfer_out) begin
                        out_vld_q <= 1'b0;
                        state_q   <= ST_EMPTY;
                    end
                end
                // in_ready is low here, so only the drain of SKID into OUT can happen.
                ST_FULL: begin
                    if (xfer_out) begin
                        out_q    <= skid_q;
                        in_rdy_q <= 1'b1;
                        state_q  <= ST_ONE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_rdy_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_opcode  = out_q.opcode;
    assign bus.out_funct3  = out_q.funct3;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vector table at full rate,
// then backpressure, flush and reset sequences.
module tb_imm_decode_stage;

    logic clk;
    logic n_reset;
    logic flush;

    imm_decode_stage_if bus ();

    imm_decode_stage dut (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic check_entry(input int idx, input logic [31:0] pc);
        logic [31:0] w;
        w = vecs[idx].instr;
        chk($sformatf("v%0d_vld", idx),    {31'b0, bus.out_valid},   32'd1);
        chk($sformatf("v%0d_pc", idx),     bus.out_pc,               pc);
        chk($sformatf("v%0d_imm", idx),    bus.out_imm,              vecs[idx].imm);
        chk($sformatf("v%0d_fmt", idx),    {29'b0, bus.out_fmt},     {29'b0, vecs[idx].fmt});
        chk($sformatf("v%0d_ill", idx),    {31'b0, bus.out_illegal}, {31'b0, vecs[idx].ill});
        chk($sformatf("v%0d_rd", idx),     {27'b0, bus.out_rd},      {27'b0, w[11:7]});
        chk($sformatf("v%0d_rs1", idx),    {27'b0, bus.out_rs1},     {27'b0, w[19:15]});
        chk($sformatf("v%0d_rs2", idx),    {27'b0, bus.out_rs2},     {27'b0, w[24:20]});
        chk($sformatf("v%0d_opc", idx),    {25'b0, bus.out_opcode},  {25'b0, w[6:0]});
        chk($sformatf("v%0d_f3", idx),     {29'b0, bus.out_funct3},  {29'b0, w[14:12]});
    endtask

    initial begin
        int  got;
        logic xi;
        logic [31:0] exp_pc [3];

        // {instr, imm, fmt, illegal}
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0}; // addi x1,x0,-1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0}; // sw x1,-4(x2)
        vecs[2]  = '{32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0}; // jal x0,-8
        vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0}; // lui x1,0x12345
        vecs[4]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0}; // beq x0,x0,-4
        vecs[5]  = '{32'h00208463, 32'h00000008, 3'd3, 1'b0}; // beq x1,x2,8
        vecs[6]  = '{32'h00001297, 32'h00001000, 3'd4, 1'b0}; // auipc x5,1
        vecs[7]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0}; // add x3,x1,x2
        vecs[8]  = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0}; // fence
        vecs[9]  = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1}; // opcode 0x7F
        vecs[10] = '{32'h80012083, 32'hFFFFF800, 3'd1, 1'b0}; // lw x1,-2048(x2)
        vecs[11] = '{32'h7FF08067, 32'h000007FF, 3'd1, 1'b0}; // jalr x0,2047(x1)
        vecs[12] = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0}; // jal x1,2048
        vecs[13] = '{32'h00000000, 32'h00000000, 3'd0, 1'b1}; // opcode 0

        n_reset       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        #2;
        chk("rst_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_rdy", {31'b0, bus.in_ready},  32'd0);
        tick();
        tick();
        chk("rst_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
        n_reset = 1'b1;
        #1;
        chk("rdy_before_edge", {31'b0, bus.in_ready}, 32'd0);
        tick();
        chk("rdy_after_edge", {31'b0, bus.in_ready},  32'd1);
        chk("vld_after_edge", {31'b0, bus.out_valid}, 32'd0);

        // Back-to-back table stream with execute always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) check_entry(i - 1, 32'h100 + 32'(4 * (i - 1)));
            if (i < NV) begin
                drive(vecs[i].instr, 32'h100 + 32'(4 * i));
                chk($sformatf("thru_rdy%0d", i), {31'b0, bus.in_ready}, 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        chk("drain_vld", {31'b0, bus.out_valid}, 32'd0);

        // Three instructions against a stalled execute: two held, third waits.
        exp_pc[0] = 32'h1000;
        exp_pc[1] = 32'h1004;
        exp_pc[2] = 32'h1008;
        bus.out_ready = 1'b0;
        drive(vecs[0].instr, exp_pc[0]);
        tick();
        drive(vecs[1].instr, exp_pc[1]);
        tick();
        drive(vecs[2].instr, exp_pc[2]);
        chk("full_rdy", {31'b0, bus.in_ready},  32'd0);
        chk("full_vld", {31'b0, bus.out_valid}, 32'd1);
        chk("full_pc",  bus.out_pc, exp_pc[0]);
        tick();
        chk("full_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
        chk("full_hold_pc",  bus.out_pc, exp_pc[0]);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (bus.out_valid) begin
                chk($sformatf("stream_pc%0d", got), bus.out_pc, exp_pc[got]);
                got++;
            end
            xi = bus.in_valid & bus.in_ready;
            tick();
            if (xi) bus.in_valid = 1'b0;
        end
        chk("stream_cnt", got, 32'd3);
        tick();
        chk("stream_empty", {31'b0, bus.out_valid}, 32'd0);

        // Flush while FULL, with a colliding in_valid.
        bus.out_ready = 1'b0;
        drive(vecs[3].instr, 32'h2000);
        tick();
        drive(vecs[4].instr, 32'h2004);
        tick();
        chk("pre_flush_rdy", {31'b0, bus.in_ready}, 32'd0);
        drive(vecs[5].instr, 32'h2008);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_full_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_full_rdy", {31'b0, bus.in_ready},  32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("flush_full_drop%0d", c), {31'b0, bus.out_valid}, 32'd0);
        end

        // Flush in ONE while the stage would accept: the new entry is dropped too.
        bus.out_ready = 1'b0;
        drive(vecs[6].instr, 32'h2100);
        tick();
        chk("one_rdy", {31'b0, bus.in_ready}, 32'd1);
        drive(vecs[7].instr, 32'h2104);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_one_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_one_rdy", {31'b0, bus.in_ready},  32'd1);
        tick();
        chk("flush_one_drop", {31'b0, bus.out_valid}, 32'd0);

        // Normal traffic resumes after flush; illegal entry flows through.
        bus.out_ready = 1'b1;
        drive(vecs[9].instr, 32'h3000);
        tick();
        bus.in_valid = 1'b0;
        check_entry(9, 32'h3000);
        tick();
        chk("post_flush_empty", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset in the middle of a transfer.
        bus.out_ready = 1'b0;
        drive(vecs[0].instr, 32'h4000);
        tick();
        drive(vecs[1].instr, 32'h4004);
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_rdy", {31'b0, bus.in_ready},  32'd0);
        tick();
        bus.in_valid = 1'b0;
        n_reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("arst_rel_rdy", {31'b0, bus.in_ready},  32'd1);
        chk("arst_rel_vld", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("arst_no_ghost", {31'b0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
